// File: rtl/mesi_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// mesi_coherence_ctrl
//   Set-associative MESI cache-state controller driven by a command trace.
//   It keeps a tag and MESI state per way and a victim pointer per set.
//   Each accepted command is looked up, may issue one or two bus operations,
//   and finishes with a single resp_valid pulse.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready   trace command handshake (ready only while idle)
//   cmd_n             opcode: 0 rd, 1 wr, 2 ifetch, 3 L2 inval, 4 snp rd,
//                     5 snp wr, 6 snp RWIM, 7 snp inval, 8 clear, 9 print
//   cmd_index/tag     set index and tag of the command
//   busop_valid/busop bus request (0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM),
//                     held until busop_ready
//   get_snoop         other caches' result, sampled at the bus handshake
//   resp_*            completion pulse with hit flag, way, final MESI state
//   snoop_resp        this cache's snoop result (0 NOHIT, 1 HIT, 2 HITM)
// ---------------------------------------------------------------------------
module mesi_coherence_ctrl #(
  parameter int SETS  = 16,
  parameter int WAYS  = 4,
  parameter int TAG_W = 12,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_n,
  input  logic [IDX_W-1:0]        cmd_index,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic                    busop_valid,
  output logic [1:0]              busop,
  input  logic                    busop_ready,
  input  logic [1:0]              get_snoop,
  output logic [1:0]              snoop_resp,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic [1:0]              resp_state
);

  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB_REQ, S_BUS_REQ, S_UPDATE, S_CLEAR} fsm_t;
  typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;
  typedef enum logic [1:0] {SN_NOHIT, SN_HIT, SN_HITM} snp_t;
  typedef enum logic [1:0] {BUS_READ, BUS_WRITE, BUS_INVAL, BUS_RWIM} bus_t;
  typedef enum logic [3:0] {OP_RD, OP_WR, OP_IF, OP_L2INV, OP_SRD, OP_SWR,
                            OP_SRWIM, OP_SINV, OP_CLR} op_t;

  mesi_t            st_arr  [SETS][WAYS];
  logic [TAG_W-1:0] tag_arr [SETS][WAYS];
  logic [WAY_W-1:0] ptr_arr [SETS];

  fsm_t             fsm_q;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx_q, clr_idx;
  logic [TAG_W-1:0] ctag_q;
  logic [WAY_W-1:0] way_q;
  mesi_t            new_st_q;
  logic             wr_q, adv_q, chain_q, fill_q, hit_q;
  bus_t             bus2_q;
  snp_t             snp_q;

  // Lookup results for the registered command
  logic             hit;
  logic [WAY_W-1:0] hit_way, vic_way;
  mesi_t            hit_st, vic_st, fill_st;

  // Decision taken in LOOKUP
  fsm_t             d_next;
  bus_t             d_busop, d_bus2;
  logic [WAY_W-1:0] d_way;
  mesi_t            d_st;
  logic             d_wr, d_adv, d_chain, d_fill, d_hit;
  snp_t             d_snp;

  // Scan from the top way down so the lowest matching / free way wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hit     = 1'b0;
    hit_way = '0;
    hit_st  = ST_I;
    vic_way = ptr_arr[idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (st_arr[idx_q][w] != ST_I && tag_arr[idx_q][w] == ctag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_st  = st_arr[idx_q][w];
      end
      if (st_arr[idx_q][w] == ST_I) vic_way = WAY_W'(w);
    end
    vic_st = st_arr[idx_q][vic_way];
  end

  // A read fill becomes E only when no other cache holds the line.
  assign fill_st = fill_q ? ((get_snoop == SN_NOHIT) ? ST_E : ST_S) : new_st_q;

  always_comb begin
    d_next  = S_UPDATE;
    d_busop = BUS_READ;
    d_bus2  = BUS_READ;
    d_chain = 1'b0;
    d_way   = hit ? hit_way : '0;
    d_st    = hit ? hit_st : ST_I;
    d_wr    = 1'b0;
    d_adv   = 1'b0;
    d_fill  = 1'b0;
    d_hit   = hit;
    d_snp   = SN_NOHIT;
    case (op_q)
      OP_RD, OP_IF, OP_WR: begin
        if (!hit) begin
          d_way  = vic_way;
          d_adv  = (vic_st != ST_I);
          d_wr   = 1'b1;
          d_fill = (op_q != OP_WR);
          d_st   = (op_q == OP_WR) ? ST_M : ST_E;
          d_bus2 = (op_q == OP_WR) ? BUS_RWIM : BUS_READ;
          if (vic_st == ST_M) begin
            d_next  = S_WB_REQ;
            d_busop = BUS_WRITE;
            d_chain = 1'b1;
          end else begin
            d_next  = S_BUS_REQ;
            d_busop = d_bus2;
          end
        end else if (op_q == OP_WR) begin
          d_wr = 1'b1;
          d_st = ST_M;
          if (hit_st == ST_S) begin
            d_next  = S_BUS_REQ;
            d_busop = BUS_INVAL;
          end
        end
      end
      OP_L2INV: if (hit) begin
        d_wr = 1'b1;
        d_st = ST_I;
      end
      OP_SRD, OP_SRWIM: if (hit) begin
        d_wr  = 1'b1;
        d_st  = (op_q == OP_SRD) ? ST_S : ST_I;
        d_snp = SN_HIT;
        if (hit_st == ST_M) begin
          d_snp   = SN_HITM;
          d_next  = S_WB_REQ;
          d_busop = BUS_WRITE;
        end
      end
      OP_SINV: if (hit) begin
        d_snp = SN_HIT;
        if (hit_st == ST_S) begin
          d_wr = 1'b1;
          d_st = ST_I;
        end
      end
      OP_SWR: ;
      OP_CLR: begin
        d_next = S_CLEAR;
        d_hit  = 1'b0;
        d_way  = '0;
        d_st   = ST_I;
      end
      default: begin
        d_hit = 1'b0;
        d_way = '0;
        d_st  = ST_I;
      end
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the tag/state/pointer arrays are reset too, because an
      // uninitialised state word would read as a valid line after reset.
      for (int s = 0; s < SETS; s++) begin
        ptr_arr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          st_arr[s][w]  <= ST_I;
          tag_arr[s][w] <= '0;
        end
      end
      fsm_q       <= S_IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      ctag_q      <= '0;
      clr_idx     <= '0;
      way_q       <= '0;
      new_st_q    <= ST_I;
      wr_q        <= 1'b0;
      adv_q       <= 1'b0;
      chain_q     <= 1'b0;
      fill_q      <= 1'b0;
      hit_q       <= 1'b0;
      bus2_q      <= BUS_READ;
      snp_q       <= SN_NOHIT;
      cmd_ready   <= 1'b0;
      busop_valid <= 1'b0;
      busop       <= BUS_READ;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_state  <= ST_I;
      snoop_resp  <= SN_NOHIT;
    end else begin
      resp_valid <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_n;
            idx_q     <= cmd_index;
            ctag_q    <= cmd_tag;
            cmd_ready <= 1'b0;
            fsm_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          way_q    <= d_way;
          new_st_q <= d_st;
          wr_q     <= d_wr;
          adv_q    <= d_adv;
          chain_q  <= d_chain;
          fill_q   <= d_fill;
          hit_q    <= d_hit;
          snp_q    <= d_snp;
          bus2_q   <= d_bus2;
          clr_idx  <= '0;
          fsm_q    <= d_next;
          if (d_next == S_WB_REQ || d_next == S_BUS_REQ) begin
            busop_valid <= 1'b1;
            busop       <= d_busop;
          end else if (d_next == S_UPDATE) begin
            resp_valid <= 1'b1;
            resp_hit   <= d_hit;
            resp_way   <= d_way;
            resp_state <= d_st;
            snoop_resp <= d_snp;
          end
        end
        S_WB_REQ: if (busop_ready) begin
          if (chain_q) begin
            busop <= bus2_q;
            fsm_q <= S_BUS_REQ;
          end else begin
            busop_valid <= 1'b0;
            fsm_q       <= S_UPDATE;
            resp_valid  <= 1'b1;
            resp_hit    <= hit_q;
            resp_way    <= way_q;
            resp_state  <= new_st_q;
            snoop_resp  <= snp_q;
          end
        end
        S_BUS_REQ: if (busop_ready) begin
          busop_valid <= 1'b0;
          new_st_q    <= fill_st;
          fsm_q       <= S_UPDATE;
          resp_valid  <= 1'b1;
          resp_hit    <= hit_q;
          resp_way    <= way_q;
          resp_state  <= fill_st;
          snoop_resp  <= snp_q;
        end
        S_UPDATE: begin
          if (wr_q) begin
            st_arr[idx_q][way_q]  <= new_st_q;
            tag_arr[idx_q][way_q] <= ctag_q;
          end
          if (adv_q)
            ptr_arr[idx_q] <= (ptr_arr[idx_q] == WAY_W'(WAYS - 1)) ? '0 : ptr_arr[idx_q] + 1'b1;
          cmd_ready <= 1'b1;
          fsm_q     <= S_IDLE;
        end
        S_CLEAR: begin
          ptr_arr[clr_idx] <= '0;
          for (int w = 0; w < WAYS; w++) st_arr[clr_idx][w] <= ST_I;
          if (clr_idx == IDX_W'(SETS - 1)) begin
            fsm_q      <= S_UPDATE;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_state <= ST_I;
            snoop_resp <= SN_NOHIT;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mesi_coherence_ctrl
//   Directed trace of commands against mesi_coherence_ctrl with
//   hand-computed expected bus operations and responses.
// ---------------------------------------------------------------------------
module tb_mesi_coherence_ctrl;

  localparam int SETS = 16, WAYS = 4, TAG_W = 12, IDX_W = 4;

  localparam logic [3:0] RD = 4'd0, WR = 4'd1, L2I = 4'd3, SRD = 4'd4, SWR = 4'd5,
                         SRWIM = 4'd6, SINV = 4'd7, CLR = 4'd8, PRT = 4'd9;
  localparam logic [1:0] B_RD = 2'd0, B_WR = 2'd1, B_INV = 2'd2, B_RWIM = 2'd3;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
  localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_n;
  logic [IDX_W-1:0] cmd_index;
  logic [TAG_W-1:0] cmd_tag;
  logic             busop_valid, busop_ready;
  logic [1:0]       busop, get_snoop, snoop_resp, resp_state;
  logic             resp_valid, resp_hit;
  logic [1:0]       resp_way;

  mesi_coherence_ctrl #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n),
    .cmd_index(cmd_index), .cmd_tag(cmd_tag),
    .busop_valid(busop_valid), .busop(busop), .busop_ready(busop_ready),
    .get_snoop(get_snoop), .snoop_resp(snoop_resp),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_state(resp_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations of the last command
  logic [1:0] bus_log [8];
  int         bus_n, lat, ready_hi, stall_left, stall_seen, unstable;
  logic [1:0] first_op;
  logic       r_hit;
  logic [1:0] r_way, r_state, r_snp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [IDX_W-1:0] idx,
                          input logic [TAG_W-1:0] tag);
    int n;
    @(negedge clk);
    cmd_n = op; cmd_index = idx; cmd_tag = tag; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    bit done;
    done = 0; lat = 0; ready_hi = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      lat++;
      if (cmd_ready) ready_hi++;
      if (busop_valid) begin
        if (stall_left > 0) begin
          busop_ready = 1'b0;
          if (stall_seen == 0) first_op = busop;
          else if (busop !== first_op) unstable++;
          stall_seen++;
          stall_left--;
        end else begin
          busop_ready = 1'b1;
          if (bus_n < 8) bus_log[bus_n] = busop;
          bus_n++;
        end
      end else begin
        busop_ready = 1'b0;
      end
      if (resp_valid) begin
        r_hit = resp_hit; r_way = resp_way; r_state = resp_state; r_snp = snoop_resp;
        done = 1;
      end
    end
    busop_ready = 1'b0;
    if (!done) check("resp_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [IDX_W-1:0] idx,
                         input logic [TAG_W-1:0] tag, input logic [1:0] snp, input int stall);
    get_snoop = snp; stall_left = stall; stall_seen = 0; unstable = 0; bus_n = 0;
    send_cmd(op, idx, tag);
    wait_resp(200);
  endtask

  // One command, checking busop count/first op and the response fields
  task automatic expect_resp(input string tag, input int nbus, input logic [1:0] op0,
                             input logic hit, input logic [1:0] way, input logic [1:0] st,
                             input logic [1:0] snp);
    check({tag, "_nbus"}, bus_n, nbus);
    if (nbus > 0) check({tag, "_op0"}, bus_log[0], op0);
    check({tag, "_hit"}, r_hit, hit);
    check({tag, "_way"}, r_way, way);
    check({tag, "_state"}, r_state, st);
    check({tag, "_snp"}, r_snp, snp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_n = '0; cmd_index = '0; cmd_tag = '0;
    busop_ready = 1'b0; get_snoop = NOHIT;
    stall_left = 0; stall_seen = 0; unstable = 0; bus_n = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busop_valid", busop_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_outs", {busop, snoop_resp, resp_way, resp_state, resp_hit}, 0);
    rst = 1'b1;
    #1 check("rel_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("rel_ready_high", cmd_ready, 1);

    // Cold read miss, then read hit (2-cycle latency), then silent E->M write
    run_cmd(RD, 2, 12'h984, NOHIT, 0);
    expect_resp("rd_miss", 1, B_RD, 0, 0, E, NOHIT);
    run_cmd(RD, 2, 12'h984, NOHIT, 0);
    expect_resp("rd_hit", 0, B_RD, 1, 0, E, NOHIT);
    check("rd_hit_lat", lat, 2);
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
    run_cmd(WR, 2, 12'h984, NOHIT, 0);
    expect_resp("wr_hit_e", 0, B_RD, 1, 0, M, NOHIT);

    // Fill ways 1..3 with M lines via write misses
    for (int w = 1; w < 4; w++) begin
      run_cmd(WR, 2, 12'h100 + 12'(w), NOHIT, 0);
      expect_resp($sformatf("wr_miss%0d", w), 1, B_RWIM, 0, 2'(w), M, NOHIT);
    end

    // Full set of M lines: writeback then read, way 0 replaced, pointer -> 1
    run_cmd(RD, 2, 12'h777, HIT, 0);
    expect_resp("evict0", 2, B_WR, 0, 0, S, NOHIT);
    check("evict0_op1", bus_log[1], B_RD);
    run_cmd(RD, 2, 12'h778, NOHIT, 0);
    expect_resp("evict1", 2, B_WR, 0, 1, E, NOHIT);
    check("evict1_op1", bus_log[1], B_RD);

    // Snoops: w0 777 S, w1 778 E, w2 102 M, w3 103 M
    run_cmd(SRD, 2, 12'h102, NOHIT, 0);
    expect_resp("srd_m", 1, B_WR, 1, 2, S, HITM);
    run_cmd(SRWIM, 2, 12'h102, NOHIT, 0);
    expect_resp("srwim_s", 0, B_RD, 1, 2, I, HIT);
    run_cmd(SRD, 2, 12'h778, NOHIT, 0);
    expect_resp("srd_e", 0, B_RD, 1, 1, S, HIT);
    run_cmd(SINV, 2, 12'h778, NOHIT, 0);
    expect_resp("sinv_s", 0, B_RD, 1, 1, I, HIT);
    run_cmd(SRD, 2, 12'h555, NOHIT, 0);
    expect_resp("srd_miss", 0, B_RD, 0, 0, I, NOHIT);
    run_cmd(SINV, 2, 12'h103, NOHIT, 0);
    expect_resp("sinv_m", 0, B_RD, 1, 3, M, HIT);

    // Write hit on S with the bus stalled five cycles
    run_cmd(WR, 2, 12'h777, NOHIT, 5);
    expect_resp("wr_s", 1, B_INV, 1, 0, M, NOHIT);
    check("wr_s_stall", stall_seen, 5);
    check("wr_s_stall_op", first_op, B_INV);
    check("wr_s_stable", unstable, 0);

    // Free ways 1,2 are used lowest first without moving the pointer (still 2)
    run_cmd(RD, 2, 12'h888, NOHIT, 0);
    expect_resp("fill_i1", 1, B_RD, 0, 1, E, NOHIT);
    run_cmd(RD, 2, 12'h889, NOHIT, 0);
    expect_resp("fill_i2", 1, B_RD, 0, 2, E, NOHIT);
    run_cmd(RD, 2, 12'h88a, NOHIT, 0);
    expect_resp("evict_e2", 1, B_RD, 0, 2, E, NOHIT);

    // L2 invalidate, print, unknown opcode, snoop write
    run_cmd(L2I, 2, 12'h777, NOHIT, 0);
    expect_resp("l2i_hit", 0, B_RD, 1, 0, I, NOHIT);
    run_cmd(L2I, 2, 12'h999, NOHIT, 0);
    expect_resp("l2i_miss", 0, B_RD, 0, 0, I, NOHIT);
    run_cmd(PRT, 2, 12'h888, NOHIT, 0);
    expect_resp("print", 0, B_RD, 0, 0, I, NOHIT);
    run_cmd(4'd15, 2, 12'h888, NOHIT, 0);
    expect_resp("op15", 0, B_RD, 0, 0, I, NOHIT);
    run_cmd(SWR, 2, 12'h888, NOHIT, 0);
    check("swr_nbus", bus_n, 0);
    check("swr_snp", r_snp, NOHIT);
    run_cmd(RD, 2, 12'h888, NOHIT, 0);
    expect_resp("after_swr", 0, B_RD, 1, 1, E, NOHIT);

    // Line in the last set, then clear everything
    run_cmd(WR, 15, 12'habc, NOHIT, 0);
    expect_resp("set15_wr", 1, B_RWIM, 0, 0, M, NOHIT);
    run_cmd(CLR, 0, 12'h000, NOHIT, 0);
    check("clr_long", (lat >= 17) ? 1 : 0, 1);
    check("clr_ready_low", ready_hi, 0);
    check("clr_nbus", bus_n, 0);
    run_cmd(RD, 15, 12'habc, NOHIT, 0);
    expect_resp("clr_set15", 1, B_RD, 0, 0, E, NOHIT);
    run_cmd(RD, 2, 12'h888, NOHIT, 0);
    expect_resp("clr_set2", 1, B_RD, 0, 0, E, NOHIT);

    // Reset while a bus read is pending
    get_snoop = NOHIT; stall_left = 0; busop_ready = 1'b0;
    send_cmd(RD, 5, 12'h123);
    n = 0;
    while (!busop_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_busop_seen", busop_valid, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("mid_rst_busop", busop_valid, 0);
    check("mid_rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", cmd_ready, 1);
    run_cmd(RD, 5, 12'h123, NOHIT, 0);
    expect_resp("mid_nocommit", 1, B_RD, 0, 0, E, NOHIT);
    run_cmd(RD, 2, 12'h888, NOHIT, 0);
    expect_resp("mid_lost", 1, B_RD, 0, 0, E, NOHIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesi_coherence_ctrl.md
MESI_COHERENCE_CTRL -- requirements
Module: mesi_coherence_ctrl

Interface
REQ-001 SHALL have parameters: SETS, default 16, sets per cache; WAYS, default 4, ways per set; TAG_W, default 12, tag width; IDX_W = $clog2(SETS), derived.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports as follows, clock and reset first.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  trace command present.
REQ-006 cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-007 cmd_n  in  4  trace opcode (0 rd, 1 wr, 2 ifetch, 3 L2 inval, 4 snp rd, 5 snp wr, 6 snp RWIM, 7 snp inval, 8 clear, 9 print).
REQ-008 cmd_index  in  IDX_W  set index.
REQ-009 cmd_tag  in  TAG_W  tag.
REQ-010 busop_valid  out  1  bus operation request.
REQ-011 busop  out  2  bus operation code (0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM).
REQ-012 busop_ready  in  1  bus accepts busop.
REQ-013 get_snoop  in  2  other-cache result, sampled with busop handshake (0 NOHIT, 1 HIT, 2 HITM).
REQ-014 snoop_resp  out  2  this cache's snoop result (0 NOHIT, 1 HIT, 2 HITM); valid with resp_valid.
REQ-015 resp_valid  out  1  one-cycle completion pulse.
REQ-016 resp_hit  out  1  tag matched a non-I line.
REQ-017 resp_way  out  $clog2(WAYS)  way hit or filled.
REQ-018 resp_state  out  2  final MESI state of that way (0 I, 1 S, 2 E, 3 M).

Function
REQ-019 SHALL hold per-set, per-way tag and 2-bit MESI state, plus a per-set victim pointer.
REQ-020 SHALL run FSM states IDLE, LOOKUP, WB_REQ, BUS_REQ, UPDATE, CLEAR; cmd_ready SHALL be high only in IDLE.
REQ-021 IDLE->LOOKUP on handshake; command fields are registered at handshake.
REQ-022 LOOKUP: hit = tag match with state != I; on multiple matches the lowest way wins.
REQ-023 Rd/ifetch hit: state unchanged; UPDATE next cycle; resp_valid exactly 2 cycles after handshake.
REQ-024 Rd/ifetch miss: victim = lowest I way, else pointer way. Victim in M -> WB_REQ (busop WRITE) first. Then BUS_REQ READ. Fill state: E if get_snoop NOHIT, else S.
REQ-025 Wr hit: M stays M; E->M silently; S->INVALIDATE busop, then M.
REQ-026 Wr miss: victim as REQ-024, optional WRITE writeback, then RWIM busop; fill M.
REQ-027 Pointer SHALL advance only when a valid (non-I) line is evicted, wrapping WAYS-1 -> 0.
REQ-028 busop_valid/busop SHALL stay stable until the cycle busop_ready is high; the FSM SHALL wait indefinitely.
REQ-029 Snp rd: M->S, HITM, WRITE writeback; E->S HIT; S stays, HIT; miss NOHIT.
REQ-030 Snp RWIM: M->I, HITM, WRITE writeback; E/S->I HIT; miss NOHIT.
REQ-031 Snp inval: S->I HIT; M/E unchanged HIT; miss NOHIT. Snp wr: no change, NOHIT.
REQ-032 Cmd 3: matching line forced I, no busop, resp_hit reflects match.
REQ-033 Cmd 8: CLEAR invalidates one set per cycle, index 0..SETS-1, and zeroes pointers; single resp_valid after the last set; cmd_ready low throughout.
REQ-034 Cmd 9 and opcodes >9: no state change; resp_valid in UPDATE with resp_hit=0, snoop_resp NOHIT.
REQ-035 Tag, state and pointer writes SHALL commit in UPDATE only; snoop_resp is NOHIT for non-snoop commands.

Reset
REQ-036 rst low SHALL asynchronously force: all states I, tags 0, pointers 0, FSM IDLE, busop_valid, resp_valid, resp_hit 0, busop/snoop_resp/resp_way/resp_state 0, cmd_ready 0.
REQ-037 cmd_ready SHALL rise the first cycle after rst deasserts.
REQ-038 Reset mid-operation SHALL drop any pending busop with no state committed; no handshake completes during reset.

Verification
REQ-039 Empty cache; rd idx 2 tag 0x984; busop_ready=1, get_snoop NOHIT -> busop READ; resp_hit=0, way 0, state E.
REQ-040 Repeat REQ-039 rd -> no busop; resp_valid 2 cycles after handshake; hit=1, E. Then wr -> no busop, state M.
REQ-041 Fill set 2 ways 0-3 in M; rd new tag 0x777 -> WRITE, then READ; way 0 replaced; pointer=1.
REQ-042 Line M, snp rd same tag -> snoop_resp HITM, WRITE busop, state S. Snp RWIM -> HIT, state I.
REQ-043 Line S, wr hit with busop_ready low 5 cycles -> busop INVALIDATE held stable 5 cycles; state M after accept.
REQ-044 Cmd 8 with SETS=16 -> cmd_ready low 16+ cycles; every subsequent rd misses; rst pulse mid-BUS_REQ -> busop_valid 0 at once.
